dma_copy_engine: RTL and testbench

//  Memory-to-memory copy initiator driving a byte memory port pair:
//  - read side: rd_valid/rd_addr, rd_data registered one cycle after the request.
//  - write side: wr_valid/wr_addr/wr_data, applied at the clock edge.

---
 rtl/dma_copy_engine.sv | 169 ++++++++++++++++
 tb/tb_dma_copy_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: pipelined byte-wide memory-to-memory copy initiator (one byte per cycle).
// Optional build macro DMA_CHECKSUM_EN adds a 16-bit running sum of written bytes.
`default_nettype none

module dma_copy_engine #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
`ifdef DMA_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic [LEN_W-1:0]  bytes_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [LEN_W-1:0]  rd_idx;
  logic [LEN_W-1:0]  last_idx;
  logic              pend;
  logic              abt;

  logic              active;
  logic              abort_now;
  logic              issue;
  logic              accept;

  assign active    = (state == S_RUN) || (state == S_DRAIN);
  assign abort_now = active && abort;
  assign accept    = (state == S_IDLE) && start;
  // A byte returned by memory becomes a write unless an abort is being taken this edge.
  assign issue     = pend && !abort_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rd_ptr   <= '0;
      rd_idx   <= '0;
      last_idx <= '0;
      abt      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_ptr   <= src_base;
            rd_idx   <= '0;
            last_idx <= len - LEN_ONE;
            abt      <= 1'b0;
            state    <= (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            abt   <= 1'b1;
            state <= S_DONE;
          end else begin
            rd_ptr <= rd_ptr + ADDR_ONE;
            rd_idx <= rd_idx + LEN_ONE;
            if (rd_idx == last_idx) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Once the final read strobe has dropped, the last byte is being written this edge.
          if (abort) begin
            abt   <= 1'b1;
            state <= S_DONE;
          end else if (!rd_valid) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_addr  <= '0;
    end else begin
      rd_valid <= (state == S_RUN) && !abort;
      if ((state == S_RUN) && !abort) begin
        rd_addr <= rd_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_ptr     <= '0;
      bytes_done <= '0;
`ifdef DMA_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      pend     <= rd_valid && !abort_now;
      wr_valid <= issue;
      if (accept) begin
        wr_ptr     <= dst_base;
        bytes_done <= '0;
`ifdef DMA_CHECKSUM_EN
        checksum   <= '0;
`endif
      end else if (issue) begin
        wr_addr    <= wr_ptr;
        wr_data    <= rd_data;
        wr_ptr     <= wr_ptr + ADDR_ONE;
        bytes_done <= bytes_done + LEN_ONE;
`ifdef DMA_CHECKSUM_EN
        checksum   <= checksum + {8'h00, rd_data};
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      busy <= active;
      done <= (state == S_DONE);
      if (accept) begin
        aborted <= 1'b0;
      end else if (state == S_DONE) begin
        aborted <= abt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: self-checking bench with a byte memory and a cycle-level reference model.
`default_nettype none

module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [15:0] len;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] bytes_done;
`ifdef DMA_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dma_copy_engine #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .aborted(aborted),
`ifdef DMA_CHECKSUM_EN
    .checksum(checksum),
`endif
    .bytes_done(bytes_done)
  );

  // Byte memory: unwritten locations read back a fixed address-derived pattern.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (rd_valid) rd_data <= mem_rd(rd_addr);
    if (wr_valid) mem[wr_addr] = wr_data;
  end

  int          ex_n, ex_done, ex_busy, ex_rd;
  logic        ex_ab;
  logic [15:0] ex_cks;
  int          ob_rd, ob_wr, ob_seq_bad, ob_busy, ob_done_cyc, ob_done_cnt, ob_mem_bad;
  logic        ob_ab, ob_ab_end;
  logic [15:0] ob_bytes, ob_cks;

  // Runs one transfer. ab_edge/rp_edge: edge index at which abort/start is sampled (0 = never).
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n_len,
                         input int ab_edge, input int rp_edge, input bit ab_start);
    logic [7:0] srcb [$];
    logic [7:0] pre [$];
    int limit;
    srcb = {};
    pre  = {};
    for (int i = 0; i < n_len; i++) srcb.push_back(mem_rd(s + 32'(i)));
    for (int i = -2; i < n_len + 2; i++) pre.push_back(mem_rd(d + 32'(i)));
    if (n_len == 0) begin
      ex_n = 0; ex_done = 1; ex_busy = 0; ex_rd = 0; ex_ab = 1'b0;
    end else if (ab_edge > 0) begin
      ex_rd   = (ab_edge - 1 < n_len) ? ab_edge - 1 : n_len;
      ex_n    = (ab_edge - 3 < 0) ? 0 : ((ab_edge - 3 > n_len) ? n_len : ab_edge - 3);
      ex_done = ab_edge + 1;
      ex_busy = ab_edge;
      ex_ab   = 1'b1;
    end else begin
      ex_rd = n_len; ex_n = n_len; ex_done = n_len + 3; ex_busy = n_len + 2; ex_ab = 1'b0;
    end
    ex_cks = 16'h0000;
    for (int i = 0; i < ex_n; i++) ex_cks = ex_cks + {8'h00, srcb[i]};

    ob_rd = 0; ob_wr = 0; ob_seq_bad = 0; ob_busy = 0; ob_done_cyc = -1; ob_done_cnt = 0;
    ob_mem_bad = 0; ob_ab = 1'b0; ob_cks = 16'h0000;
    @(negedge clk);
    src_base = s; dst_base = d; len = 16'(n_len); start = 1'b1; abort = ab_start;
    @(negedge clk);
    start = (rp_edge == 1); abort = (ab_edge == 1);
    limit = ex_done + 3;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (busy) ob_busy++;
      if (done) begin
        ob_done_cnt++;
        if (ob_done_cyc < 0) begin
          ob_done_cyc = c;
          ob_ab = aborted;
        end
      end
      if (rd_valid) begin
        if (rd_addr !== s + 32'(ob_rd) || c != ob_rd + 1) ob_seq_bad++;
        ob_rd++;
      end
      if (wr_valid) begin
        if (ob_wr >= n_len) ob_seq_bad++;
        else if (wr_addr !== d + 32'(ob_wr) || c != ob_wr + 3 || wr_data !== srcb[ob_wr]) ob_seq_bad++;
        ob_wr++;
      end
      start = (c + 1 == rp_edge);
      abort = (c + 1 == ab_edge);
    end
    start = 1'b0; abort = 1'b0;
    ob_bytes  = bytes_done;
    ob_ab_end = aborted;
`ifdef DMA_CHECKSUM_EN
    ob_cks = checksum;
`else
    ob_cks = ex_cks;
`endif
    for (int i = -2; i < n_len + 2; i++) begin
      logic [7:0] want;
      want = (i >= 0 && i < ex_n) ? srcb[i] : pre[i + 2];
      if (mem_rd(d + 32'(i)) !== want) ob_mem_bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; len = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rd_valid, rd_addr, wr_valid, wr_addr, wr_data, busy, done, aborted, bytes_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd_valid=%b wr_valid=%b busy=%b done=%b bytes=%0d, want all 0",
               rd_valid, wr_valid, busy, done, bytes_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) mem[32'h10 + 32'(i)] = 8'(i + 1);
    do_copy(32'h10, 32'h80, 16, 0, 0, 1'b0);
    n_tests++;
    if (ob_done_cyc !== 19) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 19", ob_done_cyc); end
    n_tests++;
    if (ob_bytes !== 16'd16) begin n_fail++; $display("FAIL basic_bytes_done: got %0d want 16", ob_bytes); end
    n_tests++;
    if (ob_mem_bad !== 0 || ob_seq_bad !== 0) begin
      n_fail++; $display("FAIL basic_data: mem_bad=%0d seq_bad=%0d want 0/0", ob_mem_bad, ob_seq_bad);
    end
    n_tests++;
    if (ob_busy !== ex_busy || ob_done_cnt !== 1) begin
      n_fail++; $display("FAIL basic_busy_done: busy=%0d done_cnt=%0d want %0d/1", ob_busy, ob_done_cnt, ex_busy);
    end
    n_tests++;
    if (ob_cks !== 16'h0088) begin n_fail++; $display("FAIL basic_checksum: got %h want 0088", ob_cks); end
  endtask

  task automatic test_zero_len();
    do_copy(32'h500, 32'h600, 0, 0, 0, 1'b0);
    n_tests++;
    if (ob_rd !== 0 || ob_wr !== 0 || ob_busy !== 0) begin
      n_fail++; $display("FAIL zero_len_traffic: rd=%0d wr=%0d busy=%0d want 0/0/0", ob_rd, ob_wr, ob_busy);
    end
    n_tests++;
    if (ob_done_cyc !== 1 || ob_bytes !== 16'd0 || ob_ab !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_done: done_cyc=%0d bytes=%0d aborted=%b want 1/0/0", ob_done_cyc, ob_bytes, ob_ab);
    end
  endtask

  task automatic test_wrap();
    do_copy(32'hFFFF_FFFE, 32'h20, 4, 0, 0, 1'b0);
    n_tests++;
    if (ob_rd !== 4 || ob_wr !== 4 || ob_seq_bad !== 0 || ob_mem_bad !== 0) begin
      n_fail++;
      $display("FAIL wrap_addr: rd=%0d wr=%0d seq_bad=%0d mem_bad=%0d want 4/4/0/0", ob_rd, ob_wr, ob_seq_bad, ob_mem_bad);
    end
  endtask

  task automatic test_abort();
    do_copy(32'h1000, 32'h2000, 32, 6, 0, 1'b0);
    n_tests++;
    if (ob_bytes !== 16'd3 || ob_wr !== 3) begin
      n_fail++; $display("FAIL abort_bytes: bytes=%0d writes=%0d want 3/3", ob_bytes, ob_wr);
    end
    n_tests++;
    if (ob_done_cyc !== ex_done || ob_ab !== 1'b1 || ob_ab_end !== 1'b1) begin
      n_fail++; $display("FAIL abort_done: done_cyc=%0d aborted=%b held=%b want %0d/1/1", ob_done_cyc, ob_ab, ob_ab_end, ex_done);
    end
    n_tests++;
    if (ob_mem_bad !== 0 || ob_seq_bad !== 0 || ob_cks !== ex_cks) begin
      n_fail++; $display("FAIL abort_mem: mem_bad=%0d seq_bad=%0d cks=%h want 0/0/%h", ob_mem_bad, ob_seq_bad, ob_cks, ex_cks);
    end
  endtask

  task automatic test_start_abort_idle();
    do_copy(32'h700, 32'h780, 5, 0, 0, 1'b1);
    n_tests++;
    if (ob_done_cyc !== 8 || ob_bytes !== 16'd5 || ob_ab !== 1'b0) begin
      n_fail++; $display("FAIL start_abort_idle: done_cyc=%0d bytes=%0d aborted=%b want 8/5/0", ob_done_cyc, ob_bytes, ob_ab);
    end
  endtask

  task automatic test_back_to_back();
    do_copy(32'h900, 32'h980, 8, 0, 3, 1'b0);
    n_tests++;
    if (ob_rd !== 8 || ob_done_cyc !== 11 || ob_bytes !== 16'd8 || ob_done_cnt !== 1) begin
      n_fail++; $display("FAIL repulse_busy: rd=%0d done_cyc=%0d bytes=%0d done_cnt=%0d want 8/11/8/1",
                         ob_rd, ob_done_cyc, ob_bytes, ob_done_cnt);
    end
    do_copy(32'hA00, 32'hA80, 8, 0, 11, 1'b0);
    n_tests++;
    if (ob_rd !== 8 || ob_done_cnt !== 1 || ob_mem_bad !== 0) begin
      n_fail++; $display("FAIL repulse_done: rd=%0d done_cnt=%0d mem_bad=%0d want 8/1/0", ob_rd, ob_done_cnt, ob_mem_bad);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    src_base = 32'h100; dst_base = 32'h200; len = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rd_valid, rd_addr, wr_valid, wr_addr, wr_data, busy, done, aborted, bytes_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rd_valid=%b wr_valid=%b busy=%b bytes=%0d, want all 0",
               rd_valid, wr_valid, busy, bytes_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_copy(32'h300, 32'h400, 6, 0, 0, 1'b0);
    n_tests++;
    if (ob_done_cyc !== 9 || ob_bytes !== 16'd6 || ob_mem_bad !== 0 || ob_seq_bad !== 0) begin
      n_fail++; $display("FAIL reset_mid_rerun: done_cyc=%0d bytes=%0d mem_bad=%0d seq_bad=%0d want 9/6/0/0",
                         ob_done_cyc, ob_bytes, ob_mem_bad, ob_seq_bad);
    end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 8; i++) mem[32'h40 + 32'(i)] = 8'($urandom);
    do_copy(32'h40, 32'h3E, 8, 0, 0, 1'b0);
    n_tests++;
    if (ob_mem_bad !== 0 || ob_seq_bad !== 0) begin
      n_fail++; $display("FAIL overlap_down: mem_bad=%0d seq_bad=%0d want 0/0", ob_mem_bad, ob_seq_bad);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int l, e;
      logic [31:0] s, d;
      l = int'($urandom_range(1, 40));
      s = $urandom;
      if ($urandom_range(0, 1) == 1) d = s - 32'($urandom_range(0, 60));
      else d = s + 32'(l) + 32'($urandom_range(0, 200));
      e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, l + 2)) : 0;
      do_copy(s, d, l, e, 0, 1'b0);
      n_tests++;
      if (ob_done_cyc !== ex_done || ob_bytes !== 16'(ex_n) || ob_ab !== ex_ab || ob_rd !== ex_rd ||
          ob_busy !== ex_busy || ob_mem_bad !== 0 || ob_seq_bad !== 0 || ob_cks !== ex_cks) begin
        n_fail++;
        $display("FAIL random_%0d: len=%0d abort_edge=%0d done_cyc=%0d/%0d bytes=%0d/%0d aborted=%b/%b rd=%0d/%0d busy=%0d/%0d mem_bad=%0d seq_bad=%0d cks=%h/%h",
                 it, l, e, ob_done_cyc, ex_done, ob_bytes, ex_n, ob_ab, ex_ab, ob_rd, ex_rd,
                 ob_busy, ex_busy, ob_mem_bad, ob_seq_bad, ob_cks, ex_cks);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_reset_mid();
    test_overlap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
